// File: rtl/memory_arbiter_pkg.sv
// Shared state encoding and default geometry for memory_arbiter and the memory it fronts.
package memory_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_START  = 2'd0,
        ST_INIT   = 2'd1,
        ST_IDLE   = 2'd2,
        ST_ACCESS = 2'd3
    } state_t;

    localparam int DEF_CELL_COUNT = 4;
    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_DATA_WIDTH = 8;

endpackage

// File: rtl/memory_arbiter.sv
// Clears memory after reset/clear, then round-robin shares it between two req/ack requesters.
// Latency: req sampled in IDLE at edge k, ack and rdata valid during cycle k->k+1.
// Backpressure: requesters hold req until ack; at most one transaction per 2 cycles, none while clearing.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int CELL_COUNT = DEF_CELL_COUNT,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  ack0,
    output logic                  ack1,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  ready,
    output logic [ADDR_WIDTH-1:0] read_address,
    output logic [ADDR_WIDTH-1:0] write_address,
    output logic [DATA_WIDTH-1:0] write_data,
    output logic                  write_enable,
    input  logic [DATA_WIDTH-1:0] read_data
);

    localparam logic [ADDR_WIDTH-1:0] LAST_CELL  = ADDR_WIDTH'(CELL_COUNT - 1);
    localparam logic [ADDR_WIDTH-1:0] CELL_LIMIT = ADDR_WIDTH'(CELL_COUNT);

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] count;
    logic                  last;
    logic                  owner;
    logic                  lat_we;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic                  clear_pend;
    logic                  clear_now;
    logic                  pick;
    logic                  grant;
    logic                  lat_in_range;

    // On contention the requester that was not served last wins.
    assign pick         = (req0 && req1) ? ~last : req1;
    assign clear_now    = clear || clear_pend;
    assign lat_in_range = (lat_addr < CELL_LIMIT);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= ST_START;
            count      <= '0;
            last       <= 1'b1;
            owner      <= 1'b0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            clear_pend <= 1'b0;
        end else begin
            state      <= state_nxt;
            // A clear arriving mid-access waits for the IDLE cycle that follows.
            clear_pend <= (state == ST_ACCESS) && clear;
            if (state == ST_INIT) begin
                count <= (count == LAST_CELL) ? '0 : count + ADDR_WIDTH'(1);
            end
            if (grant) begin
                owner     <= pick;
                lat_we    <= pick ? we1    : we0;
                lat_addr  <= pick ? addr1  : addr0;
                lat_wdata <= pick ? wdata1 : wdata0;
            end
            if (state == ST_ACCESS) begin
                last <= owner;
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        grant         = 1'b0;
        ack0          = 1'b0;
        ack1          = 1'b0;
        rdata         = '0;
        ready         = 1'b0;
        read_address  = '0;
        write_address = '0;
        write_data    = '0;
        write_enable  = 1'b0;
        unique case (state)
            ST_START: begin
                state_nxt = ST_INIT;
            end
            ST_INIT: begin
                write_address = count;
                write_enable  = 1'b1;
                if (count == LAST_CELL) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_IDLE: begin
                ready = 1'b1;
                if (clear_now) begin
                    state_nxt = ST_INIT;
                end else if (req0 || req1) begin
                    grant     = 1'b1;
                    state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                ready         = 1'b1;
                read_address  = lat_addr;
                write_address = lat_addr;
                write_data    = lat_wdata;
                write_enable  = lat_we && lat_in_range;
                ack0          = ~owner;
                ack1          = owner;
                rdata         = lat_in_range ? read_data : '0;
                state_nxt     = ST_IDLE;
            end
            default: begin
                state_nxt = ST_START;
            end
        endcase
    end

endmodule
